dac_wave_gen: RTL and testbench
===============================

# dac_wave_gen

Parametrised waveform sequencer that feeds the I2C DAC write driver with periodic sample updates. It replaces the fixed-increment ramp logic in the DAC top level with programmable rate, bounds, step and waveform mode. It adds a ready handshake toward the driver and overrun detection. It sits between user/config logic and the `dac` driver's `wr_req`/`wr_data`/`wr_data_vld`/`ready` ports.

## Interface
- `DATA_W`, default 8: sample width in bits.
- `PERIOD`, default 1_000_000: clk cycles between sample ticks; legal range is ≥ 4.
- `CNT_W`, default 16: width of `sample_cnt`.
- `clk`, input, 1: system clock.
- `rst`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: run enable.
- `mode`, input, 2: waveform select. 0 = saw up, 1 = saw down, 2 = triangle, 3 = hold.
- `lo`, input, DATA_W: lower bound.
- `hi`, input, DATA_W: upper bound.
- `step`, input, DATA_W: increment per tick.
- `ready`, input, 1: DAC driver idle.
- `clr_ovr`, input, 1: single-cycle pulse that clears `overrun`.
- `wr_req`, output, 1: one-cycle write request to the driver.
- `wr_data_vld`, output, 1: identical to `wr_req`.
- `wr_data`, output, DATA_W: sample value.
- `overrun`, output, 1: sticky flag; a tick arrived while the previous sample was still pending.
- `sample_cnt`, output, CNT_W: count of issued requests; wraps modulo 2^CNT_W.

## Operation
- Reset values:
  - All outputs 0.
  - Tick counter 0.
  - State IDLE.
  - Triangle direction = up.
  - `first` flag = 1.
- Tick counter:
  - While `en` = 1, counts 0..PERIOD-1 and wraps.
  - A tick occurs in the cycle where the count equals PERIOD-1.
  - While `en` = 0, the counter is held at 0, `first` is set to 1, and state is forced to IDLE. Any pending sample is dropped with no `wr_req`.
- State machine has two states, IDLE and PEND:
  - IDLE, on tick: `wr_data` ← next value, state → PEND.
  - PEND with `ready` = 1: register `wr_req` = 1 for one cycle, state → IDLE, `sample_cnt` + 1.
  - PEND on a tick: the tick is dropped, `overrun` ← 1, and `wr_data` is unchanged.
  - If `overrun` set and `clr_ovr` occur in the same cycle, set wins.
- Next-value rules:
  - Mode and bounds are sampled on each tick.
  - Arithmetic is done in DATA_W+1 bits, so there is no silent wrap.
  - `first` = 1: value = `hi` for mode 1, otherwise `lo`. Then `first` ← 0 and direction ← up (mode 1 sets direction ← down).
  - Mode 0: v+step > hi → lo; otherwise v+step.
  - Mode 1: v < lo+step → hi; otherwise v−step.
  - Mode 2, direction up: v+step ≥ hi → hi, direction ← down; otherwise v+step.
  - Mode 2, direction down: v ≤ lo+step → lo, direction ← up; otherwise v−step.
  - Mode 3: value = lo. A write is still issued every tick.
- Degenerate configuration:
  - `lo` ≥ `hi` → behave as mode 3.
  - `step` = 0 → value unchanged, writes still issued.
- Mid-run reconfiguration: if the current v lies outside [lo, hi] at a tick, the next value is `hi` for mode 1 or direction down, otherwise `lo`. The step rule is not applied on that tick.

## Timing
- Tick at cycle T: `wr_data` is valid from T+1.
- With `ready` = 1 at T+1, `wr_req` is high during T+2 only.
- Latency from tick to `wr_req` is 2 cycles plus however many cycles `ready` stays low.
- `wr_data` is stable from T+1 until the next accepted tick. It is always stable while `wr_req` is high.
- `wr_req` is never high in two consecutive cycles.
- Inter-request spacing is ≥ PERIOD cycles unless `ready` stalls delayed a request.
- Asynchronous reset mid-PEND: `wr_req` goes low immediately and no request is issued after release.
- After `en` rises, the first tick occurs PERIOD cycles later.

## Test plan
- Saw up, bench settings:
  - Config: PERIOD=4, lo=0x70, hi=0xFF, step=1, `ready` tied 1.
  - Required `wr_data` sequence: 0x70, 0x71 … 0xFF, 0x70.
  - `wr_req` pulses every 4 cycles; `sample_cnt` = 145 after 145 requests.
- Triangle:
  - Config: lo=10, hi=20, step=4.
  - Required sequence: 10, 14, 18, 20, 16, 12, 10, 14.
- Saw down:
  - Config: lo=0, hi=9, step=3.
  - Required sequence: 9, 6, 3, 0, 9.
  - No underflow to 0xFx.
- Overrun:
  - Stimulus: hold `ready`=0 across two ticks.
  - Required: `overrun`=1 and exactly one `wr_req` after `ready` rises, carrying the first pending value.
  - `clr_ovr` pulse clears `overrun`; `clr_ovr` coincident with a new overrun leaves it at 1.
- Degenerate and enable handling:
  - lo=0x80, hi=0x40 in mode 0: every write is 0x80.
  - Drop `en` while in PEND: no `wr_req` is issued.
  - Re-enable: first value is `lo` again.
- Reset:
  - Assert `rst`=0 in the cycle before an expected `wr_req`.
  - Required: all outputs 0 immediately and no request after release until a full PERIOD has elapsed.

Source files
------------

// File: rtl/dac_wave_gen.sv
// dac_wave_gen: periodic sample sequencer for the I2C DAC write driver.
// Every PERIOD clocks (while en=1) a tick computes the next waveform sample
// (saw up, saw down, triangle, hold) within [lo, hi], parks it on wr_data and
// waits for the driver's ready before issuing a one-cycle wr_req.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   en              run enable; low holds the tick counter and drops pending work
//   mode[1:0]       0 saw up, 1 saw down, 2 triangle, 3 hold at lo
//   lo, hi, step    waveform bounds and per-tick increment
//   ready           driver idle
//   clr_ovr         pulse clearing overrun (a simultaneous new overrun wins)
//   wr_req          one-cycle write request; wr_data_vld is the same signal
//   wr_data         current sample
//   overrun         sticky: a tick arrived while a sample was still pending
//   sample_cnt      issued request count, wraps
module dac_wave_gen #(
  parameter int DATA_W = 8,
  parameter int PERIOD = 1_000_000,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] step,
  input  logic              ready,
  input  logic              clr_ovr,
  output logic              wr_req,
  output logic              wr_data_vld,
  output logic [DATA_W-1:0] wr_data,
  output logic              overrun,
  output logic [CNT_W-1:0]  sample_cnt
);

  localparam int TW = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  typedef enum logic {IDLE, PEND} state_t;

  state_t            state;
  logic [TW-1:0]     tcnt;
  logic              tick;
  logic              first;
  logic              dir_dn;

  logic [1:0]        emode;
  logic [DATA_W:0]   up_sum;   // v + step, one bit wider so overflow compares correctly
  logic [DATA_W:0]   lo_sum;   // lo + step
  logic [DATA_W-1:0] nxt_val;
  logic              nxt_dn;

  assign tick = en && (tcnt == TW'(PERIOD - 1));

  // Next sample, evaluated against the bounds/mode present at the tick.
  always_comb begin
    emode   = (lo >= hi) ? 2'd3 : mode;   // empty/inverted range degenerates to hold
    up_sum  = {1'b0, wr_data} + {1'b0, step};
    lo_sum  = {1'b0, lo} + {1'b0, step};
    nxt_val = wr_data;
    nxt_dn  = dir_dn;
    if (first) begin
      nxt_val = (emode == 2'd1) ? hi : lo;
      nxt_dn  = (emode == 2'd1);
    end else if (emode == 2'd3) begin
      nxt_val = lo;
    end else if (wr_data < lo || wr_data > hi) begin
      // bounds moved under us: restart from the edge matching the direction
      nxt_val = (emode == 2'd1 || dir_dn) ? hi : lo;
    end else begin
      case (emode)
        2'd0: nxt_val = (up_sum > {1'b0, hi}) ? lo : up_sum[DATA_W-1:0];
        2'd1: nxt_val = ({1'b0, wr_data} < lo_sum) ? hi : wr_data - step;
        default: begin
          if (!dir_dn) begin
            if (up_sum >= {1'b0, hi}) begin
              nxt_val = hi;
              nxt_dn  = 1'b1;
            end else begin
              nxt_val = up_sum[DATA_W-1:0];
            end
          end else begin
            if ({1'b0, wr_data} <= lo_sum) begin
              nxt_val = lo;
              nxt_dn  = 1'b0;
            end else begin
              nxt_val = wr_data - step;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tcnt       <= '0;
      first      <= 1'b1;
      dir_dn     <= 1'b0;
      wr_req     <= 1'b0;
      wr_data    <= '0;
      overrun    <= 1'b0;
      sample_cnt <= '0;
    end else begin
      wr_req <= 1'b0;
      if (!en) begin
        tcnt  <= '0;
        first <= 1'b1;
        state <= IDLE;            // pending sample is silently dropped
      end else begin
        tcnt <= tick ? '0 : tcnt + TW'(1);
        case (state)
          IDLE: if (tick) begin
            wr_data <= nxt_val;
            dir_dn  <= nxt_dn;
            first   <= 1'b0;
            state   <= PEND;
          end
          PEND: if (ready) begin
            wr_req     <= 1'b1;
            sample_cnt <= sample_cnt + CNT_W'(1);
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
      if (en && state == PEND && tick) overrun <= 1'b1;
      else if (clr_ovr)                overrun <= 1'b0;
    end
  end

  assign wr_data_vld = wr_req;

endmodule

// File: tb/tb_dac_wave_gen.sv
// Directed bench for dac_wave_gen with a cycle-level behavioural model and
// literal expected sample sequences.
module tb_dac_wave_gen;
  localparam int DW = 8;
  localparam int PERIOD = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, en, ready, clr_ovr;
  logic [1:0]    mode;
  logic [DW-1:0] lo, hi, stp;
  logic          wr_req, wr_data_vld, overrun;
  logic [DW-1:0] wr_data;
  logic [CW-1:0] sample_cnt;

  dac_wave_gen #(.DATA_W(DW), .PERIOD(PERIOD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .lo(lo), .hi(hi), .step(stp),
    .ready(ready), .clr_ovr(clr_ovr), .wr_req(wr_req), .wr_data_vld(wr_data_vld),
    .wr_data(wr_data), .overrun(overrun), .sample_cnt(sample_cnt));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  bit chk_on = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_req, m_ovr, first = 1, dir_dn, pend, tk_now, ovr_set;
  int m_data, m_cnt, t;

  function automatic void model_next();
    int l = lo, h = hi, s = stp, v = m_data, md = mode;
    if (l >= h) md = 3;
    if (first) begin
      v = (md == 1) ? h : l;
      dir_dn = (md == 1);
      first = 0;
    end else if (md == 3) v = l;
    else if (v < l || v > h) v = (md == 1 || dir_dn) ? h : l;
    else if (md == 0) v = (v + s > h) ? l : v + s;
    else if (md == 1) v = (v < l + s) ? h : v - s;
    else if (!dir_dn) begin
      if (v + s >= h) begin v = h; dir_dn = 1; end else v = v + s;
    end else begin
      if (v <= l + s) begin v = l; dir_dn = 0; end else v = v - s;
    end
    m_data = v;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_req = 0; m_data = 0; m_ovr = 0; m_cnt = 0; t = 0;
        first = 1; dir_dn = 0; pend = 0;
      end else begin
        m_req = 0; ovr_set = 0;
        if (!en) begin
          t = 0; first = 1; pend = 0;
        end else begin
          tk_now = (t == PERIOD - 1);
          t = (t + 1) % PERIOD;
          if (pend) begin
            if (tk_now) ovr_set = 1;
            if (ready) begin m_req = 1; pend = 0; m_cnt = (m_cnt + 1) % 65536; end
          end else if (tk_now) begin
            model_next();
            pend = 1;
          end
        end
        if (ovr_set) m_ovr = 1;
        else if (clr_ovr) m_ovr = 0;
      end
    end
  end

  // per-cycle compare, mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("wr_req", 32'(wr_req), 32'(m_req));
        chk("wr_data_vld", 32'(wr_data_vld), 32'(m_req));
        chk("wr_data", 32'(wr_data), 32'(m_data));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("sample_cnt", 32'(sample_cnt), 32'(m_cnt));
      end
    end
  end

  // request capture (DUT and model streams, plus DUT request times)
  logic [DW-1:0] dq[$];
  int mq[$], tq[$], exp_q[$];
  initial begin
    forever begin
      @(negedge clk);
      if (wr_req === 1'b1) begin dq.push_back(wr_data); tq.push_back(cyc); end
      if (m_req) mq.push_back(m_data);
    end
  end

  task automatic tk(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clrq();
    dq.delete(); mq.delete(); tq.delete();
  endtask

  task automatic collect(int n);
    int k = 0;
    while (dq.size() < n && k < n * PERIOD * 2 + 20) begin tk(1); k++; end
    if (dq.size() < n) begin
      tests++; fails++;
      $display("FAIL collect_timeout: got %0d requests expected %0d", dq.size(), n);
    end
  endtask

  task automatic chkseq(string nm);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk({nm, "_dut"}, (i < dq.size()) ? 32'(dq[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
      chk({nm, "_model"}, (i < mq.size()) ? 32'(mq[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    end
  endtask

  task automatic restart(logic [1:0] md, int l, int h, int s);
    en = 0; tk(2);
    mode = md; lo = DW'(l); hi = DW'(h); stp = DW'(s);
    clrq();
    en = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 0; en = 0; ready = 0; clr_ovr = 0; mode = 0; lo = 0; hi = 0; stp = 0;
    tk(2);
    chk_on = 1;
    tk(1);
    chk("rst_wr_req", 32'(wr_req), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_cnt", 32'(sample_cnt), 0);
    rst = 1; tk(2);

    // saw up 0x70..0xFF then wrap to 0x70
    ready = 1;
    restart(2'd0, 8'h70, 8'hFF, 1);
    collect(145);
    en = 0;
    exp_q.delete();
    for (int i = 0; i < 144; i++) exp_q.push_back(8'h70 + i);
    exp_q.push_back(8'h70);
    chkseq("sawup");
    for (int i = 1; i < 145 && i < tq.size(); i++)
      if (i == 1 || i == 143 || i == 144) chk("sawup_spacing", 32'(tq[i] - tq[i-1]), PERIOD);
    tk(1);
    chk("sawup_cnt", 32'(sample_cnt), 145);

    // triangle
    restart(2'd2, 10, 20, 4);
    collect(8);
    exp_q = '{10, 14, 18, 20, 16, 12, 10, 14};
    chkseq("tri");

    // saw down, no underflow
    restart(2'd1, 0, 9, 3);
    collect(5);
    exp_q = '{9, 6, 3, 0, 9};
    chkseq("sawdn");

    // overrun: ready low across two ticks (ticks at P4, P8, P12, P16)
    ready = 0;
    restart(2'd0, 8'h10, 8'h20, 1);
    tk(9);
    chk("ovr_set", 32'(overrun), 1);
    chk("ovr_no_req", 32'(dq.size()), 0);
    ready = 1; tk(2);
    chk("ovr_one_req", 32'(dq.size()), 1);
    chk("ovr_first_val", (dq.size() > 0) ? 32'(dq[0]) : 32'hFFFF_FFFF, 8'h10);
    clr_ovr = 1; tk(1); clr_ovr = 0; ready = 0;
    chk("ovr_cleared", 32'(overrun), 0);
    tk(3);
    clr_ovr = 1; tk(1); clr_ovr = 0;
    chk("ovr_set_wins", 32'(overrun), 1);
    ready = 1; en = 0; tk(2);
    clr_ovr = 1; tk(1); clr_ovr = 0;

    // degenerate bounds
    restart(2'd0, 8'h80, 8'h40, 1);
    collect(3);
    exp_q = '{8'h80, 8'h80, 8'h80};
    chkseq("degen");

    // mid-run bounds change, en drop while pending, re-enable
    restart(2'd0, 8'h30, 8'h50, 1);
    collect(2);
    exp_q = '{8'h30, 8'h31};
    chkseq("run");
    clrq(); lo = 8'h40;
    collect(1);
    exp_q = '{8'h40};
    chkseq("reconf");
    ready = 0; tk(4);
    clrq(); en = 0; tk(1); ready = 1; tk(6);
    chk("endrop_no_req", 32'(dq.size()), 0);
    en = 1;
    collect(1);
    exp_q = '{8'h40};
    chkseq("reenable");

    // async reset the cycle before an expected wr_req
    restart(2'd0, 8'h30, 8'h50, 1);
    tk(4);
    rst = 0; #1;
    chk("arst_wr_req", 32'(wr_req), 0);
    chk("arst_wr_data", 32'(wr_data), 0);
    chk("arst_cnt", 32'(sample_cnt), 0);
    chk("arst_overrun", 32'(overrun), 0);
    tk(2); rst = 1; clrq();
    tk(4);
    chk("arst_quiet", 32'(dq.size()), 0);
    tk(2);
    chk("arst_next_req", 32'(dq.size()), 1);
    chk("arst_next_val", (dq.size() > 0) ? 32'(dq[0]) : 32'hFFFF_FFFF, 8'h30);

    en = 0; tk(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
